// File: rtl/parity_stream_checker.sv
// Streaming parity checker: accepts samples in RUN, counts pass/fail against a parity rule
// and captures the first failure. Define PSC_ASSERT_EN for per-acceptance simulation reports.
module parity_stream_checker #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              stop_on_fail,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err_flag,
  output logic [DATA_W-1:0] first_fail_data,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  // Out-of-range MODE values fall back to the even rule.
  localparam logic [1:0]       MODE_SEL = (MODE > 2 || MODE < 0) ? 2'd0 : 2'(MODE);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_r;
  logic [CNT_W-1:0]    pass_cnt_r;
  logic [CNT_W-1:0]    fail_cnt_r;
  logic [CNT_W-1:0]    idx_r;
  logic [CNT_W-1:0]    ffi_r;
  logic [DATA_W-1:0]   ffd_r;
  logic                err_r;
  logic                alt_seen_r;
  logic                alt_exp_r;
  logic                ready_s;
  logic                accept_s;
  logic                pass_s;

  function automatic logic rule_pass(input logic par, input logic seen, input logic exp_par);
    logic ok;
    case (MODE_SEL)
      2'd1:    ok = (par == 1'b1);
      2'd2:    ok = seen ? (par == exp_par) : 1'b1;
      default: ok = (par == 1'b0);
    endcase
    return ok;
  endfunction

  // Handshake and rule evaluation for the sample currently offered.
  always_comb begin
    ready_s  = 1'b0;
    accept_s = 1'b0;
    pass_s   = 1'b0;
    ready_s  = (state_r == RUN) && !clear;
    accept_s = in_valid && ready_s;
    pass_s   = rule_pass(in_data[0], alt_seen_r, alt_exp_r);
  end

  // Control FSM, saturating counters, accept index and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pass_cnt_r <= '0;
      fail_cnt_r <= '0;
      idx_r      <= '0;
      ffi_r      <= '0;
      ffd_r      <= '0;
      err_r      <= 1'b0;
      alt_seen_r <= 1'b0;
      alt_exp_r  <= 1'b0;
    end else if (clear) begin
      state_r    <= (state_r == HALT) ? IDLE : state_r;
      pass_cnt_r <= '0;
      fail_cnt_r <= '0;
      idx_r      <= '0;
      ffi_r      <= '0;
      ffd_r      <= '0;
      err_r      <= 1'b0;
      alt_seen_r <= 1'b0;
      alt_exp_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: state_r <= enable ? RUN : IDLE;
        RUN: begin
          if (accept_s && !pass_s && stop_on_fail) begin
            state_r <= HALT;
          end else if (!enable) begin
            state_r <= IDLE;
          end else begin
            state_r <= RUN;
          end
        end
        HALT:    state_r <= HALT;
        default: state_r <= IDLE;
      endcase
      if (accept_s) begin
        idx_r <= idx_r + CNT_ONE;
        if (pass_s) begin
          if (pass_cnt_r != CNT_MAX) begin
            pass_cnt_r <= pass_cnt_r + CNT_ONE;
          end
        end else begin
          if (fail_cnt_r != CNT_MAX) begin
            fail_cnt_r <= fail_cnt_r + CNT_ONE;
          end
          err_r <= 1'b1;
          if (!err_r) begin
            ffd_r <= in_data;
            ffi_r <= idx_r;
          end
        end
        // Alternating rule: first sample seeds the expectation, later ones toggle it.
        if (MODE_SEL == 2'd2) begin
          if (!alt_seen_r) begin
            alt_seen_r <= 1'b1;
            alt_exp_r  <= ~in_data[0];
          end else begin
            alt_exp_r  <= ~alt_exp_r;
          end
        end
      end
    end
  end

  assign in_ready        = ready_s;
  assign pass_cnt        = pass_cnt_r;
  assign fail_cnt        = fail_cnt_r;
  assign err_flag        = err_r;
  assign first_fail_data = ffd_r;
  assign first_fail_idx  = ffi_r;
  assign state           = state_r;

`ifdef PSC_ASSERT_EN
  // Report the verdict of every accepted sample.
  always @(posedge clk) begin
    if (rst_n && accept_s) begin
      assert (pass_s) $info("psc pass idx %0d data %0h", idx_r, in_data);
      else $error("psc parity error idx %0d data %0h", idx_r, in_data);
    end
  end
`else
`endif

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker: several parameterisations share one stimulus
// stream; expected values go into a scoreboard queue and are popped against DUT outputs.
module tb_parity_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n, enable, stop_on_fail, clear, in_valid;
  logic [31:0] in_data;

  always #5 clk = ~clk;

  logic r0, e0, r1, e1, r2, e2, r3, e3, r4, e4;
  logic [15:0] p0, f0, i0, p1, f1, i1, p2, f2, i2, p3, f3, i3;
  logic [3:0]  p4, f4, i4;
  logic [31:0] d0, d1, d2, d3, d4;
  logic [1:0]  s0, s1, s2, s3, s4;

  parity_stream_checker #(.DATA_W(32), .CNT_W(16), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stop_on_fail(stop_on_fail), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r0), .pass_cnt(p0), .fail_cnt(f0),
    .err_flag(e0), .first_fail_data(d0), .first_fail_idx(i0), .state(s0));
  parity_stream_checker #(.DATA_W(32), .CNT_W(16), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stop_on_fail(stop_on_fail), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r1), .pass_cnt(p1), .fail_cnt(f1),
    .err_flag(e1), .first_fail_data(d1), .first_fail_idx(i1), .state(s1));
  parity_stream_checker #(.DATA_W(32), .CNT_W(16), .MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stop_on_fail(stop_on_fail), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r2), .pass_cnt(p2), .fail_cnt(f2),
    .err_flag(e2), .first_fail_data(d2), .first_fail_idx(i2), .state(s2));
  parity_stream_checker #(.DATA_W(32), .CNT_W(16), .MODE(3)) u_m3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stop_on_fail(stop_on_fail), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r3), .pass_cnt(p3), .fail_cnt(f3),
    .err_flag(e3), .first_fail_data(d3), .first_fail_idx(i3), .state(s3));
  parity_stream_checker #(.DATA_W(32), .CNT_W(4), .MODE(0)) u_c4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stop_on_fail(stop_on_fail), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r4), .pass_cnt(p4), .fail_cnt(f4),
    .err_flag(e4), .first_fail_data(d4), .first_fail_idx(i4), .state(s4));

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t x;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; stop_on_fail = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = 32'd0;
    #1;
    push("rst_state", 64'd0); push("rst_pass", 64'd0); push("rst_err", 64'd0);
    push("rst_ffd", 64'd0);   push("rst_ready", 64'd0);
    pop_check(s0); pop_check(p0); pop_check(e0); pop_check(d0); pop_check(r0);
    tick(); tick();
    rst_n = 1'b1;

    // Values 1..10 back-to-back in every mode.
    enable = 1'b1;
    tick();
    push("run_state", 64'd1); push("run_ready", 64'd1);
    pop_check(s0); pop_check(r0);
    for (int k = 1; k <= 10; k++) send(32'(k));
    push("m0_pass", 64'd5); push("m0_fail", 64'd5); push("m0_err", 64'd1);
    push("m0_ffd", 64'd1);  push("m0_ffi", 64'd0);
    push("m3_pass", 64'd5); push("m3_fail", 64'd5);
    push("m1_pass", 64'd5); push("m1_ffd", 64'd2); push("m1_ffi", 64'd1);
    push("m2_pass", 64'd10); push("m2_fail", 64'd0); push("m2_err", 64'd0);
    push("c4_pass", 64'd5);
    pop_check(p0); pop_check(f0); pop_check(e0); pop_check(d0); pop_check(i0);
    pop_check(p3); pop_check(f3);
    pop_check(p1); pop_check(d1); pop_check(i1);
    pop_check(p2); pop_check(f2); pop_check(e2);
    pop_check(p4);
    enable = 1'b0;
    tick();
    push("idle_state", 64'd0); push("idle_ready", 64'd0);
    pop_check(s0); pop_check(r0);

    // Alternating rule with 3,4,5,6,8 then an enable-falling acceptance.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push("clr_m2_pass", 64'd0); push("clr_m2_err", 64'd0);
    pop_check(p2); pop_check(e2);
    enable = 1'b1;
    tick();
    send(32'd3); send(32'd4); send(32'd5); send(32'd6); send(32'd8);
    push("m2_alt_pass", 64'd4); push("m2_alt_fail", 64'd1);
    push("m2_alt_ffi", 64'd4);  push("m2_alt_ffd", 64'd8);
    pop_check(p2); pop_check(f2); pop_check(i2); pop_check(d2);
    enable = 1'b0;
    send(32'd10);
    push("fall_state", 64'd0); push("fall_accept", 64'd5);
    pop_check(s2); pop_check(p2);
    send(32'd12);
    push("idle_no_accept", 64'd5);
    pop_check(p2);

    // Odd rule with stop_on_fail: 4 halts, 5 is refused, clear returns to IDLE.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    stop_on_fail = 1'b1;
    enable = 1'b1;
    tick();
    send(32'd1); send(32'd3); send(32'd4);
    push("halt_state", 64'd2); push("halt_ready", 64'd0);
    pop_check(s1); pop_check(r1);
    send(32'd5);
    push("halt_pass", 64'd2); push("halt_fail", 64'd1); push("halt_ffd", 64'd4);
    push("halt_ffi", 64'd2);  push("halt_hold", 64'd2);
    pop_check(p1); pop_check(f1); pop_check(d1); pop_check(i1); pop_check(s1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    stop_on_fail = 1'b0;
    push("clr_state", 64'd0); push("clr_pass", 64'd0); push("clr_fail", 64'd0);
    push("clr_err", 64'd0);   push("clr_ffd", 64'd0);  push("clr_ffi", 64'd0);
    pop_check(s1); pop_check(p1); pop_check(f1); pop_check(e1); pop_check(d1); pop_check(i1);

    // Narrow counters: saturation of pass_cnt and wrapped failure index.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) send(32'(2 * k));
    push("sat_pass", 64'd15); push("sat_fail", 64'd0); push("wide_pass", 64'd20);
    pop_check(p4); pop_check(f4); pop_check(p0);
    send(32'd7);
    push("wrap_fail", 64'd1); push("wrap_ffi", 64'd4); push("wrap_ffd", 64'd7);
    push("wrap_err", 64'd1);
    pop_check(f4); pop_check(i4); pop_check(d4); pop_check(e4);

    // Clear coincident with a valid sample while running.
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd2;
    #1;
    push("clr_ready", 64'd0);
    pop_check(r0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    push("clr_run_state", 64'd1); push("clr_run_pass", 64'd0);
    push("clr_run_fail", 64'd0);  push("clr_run_err", 64'd0);
    pop_check(s0); pop_check(p0); pop_check(f0); pop_check(e0);
    send(32'd5);
    push("post_clr_ffi", 64'd0); push("post_clr_ffd", 64'd5); push("post_clr_fail", 64'd1);
    pop_check(i0); pop_check(d0); pop_check(f0);

    // Asynchronous reset between edges while samples are in flight.
    send(32'd6);
    in_valid = 1'b1;
    in_data = 32'd9;
    rst_n = 1'b0;
    #1;
    push("arst_state", 64'd0); push("arst_pass", 64'd0); push("arst_fail", 64'd0);
    push("arst_err", 64'd0);   push("arst_ffd", 64'd0);  push("arst_ready", 64'd0);
    pop_check(s0); pop_check(p0); pop_check(f0); pop_check(e0); pop_check(d0); pop_check(r0);
    #1;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    push("rel_state", 64'd1); push("rel_no_accept", 64'd0); push("rel_fail", 64'd0);
    pop_check(s0); pop_check(p0); pop_check(f0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
